// File: rtl/icetap_readout_ctrl.sv
// Readout controller: walks the trace buffer read pointer over a captured window
// and streams each sample to the host with a valid/ready handshake.
module icetap_readout_ctrl #(
  parameter int NR_SIGNALS   = 16,
  parameter int RECORD_DEPTH = 256,
  parameter int RD_LATENCY   = 2,
  localparam int ADDR_BITS   = $clog2(RECORD_DEPTH)
) (
  input  logic                  scan_clk,
  input  logic                  scan_reset,
  input  logic                  start,
  input  logic [1:0]            capture_state,
  input  logic [ADDR_BITS-1:0]  start_addr,
  input  logic [ADDR_BITS-1:0]  stop_addr,
  output logic                  read_req_first,
  output logic                  read_req_next,
  input  logic [NR_SIGNALS-1:0] read_data,
  output logic                  out_valid,
  output logic [NR_SIGNALS-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WCNT_W-1:0]    WCNT_LOAD = WCNT_W'(RD_LATENCY - 1);
  localparam logic [WCNT_W-1:0]    WCNT_ONE  = 1;
  localparam logic [ADDR_BITS-1:0] SKIP_ONE  = 1;
  localparam logic [ADDR_BITS:0]   REM_ONE   = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT,
    ST_PRESENT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    skip_q, skip_d;
  logic [ADDR_BITS:0]      rem_q, rem_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [NR_SIGNALS-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    req_first, req_next, start_rej;

  // Window length in words; the subtraction wraps naturally at the buffer size.
  function automatic logic [ADDR_BITS:0] window_len(input logic [ADDR_BITS-1:0] first,
                                                    input logic [ADDR_BITS-1:0] last);
    logic [ADDR_BITS-1:0] span;
    span = last - first;
    return {1'b0, span} + REM_ONE;
  endfunction

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    rem_d     = rem_q;
    wcnt_d    = wcnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    req_first = 1'b0;
    req_next  = 1'b0;
    start_rej = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (capture_state == 2'd0) begin
            rem_d     = window_len(start_addr, stop_addr);
            skip_d    = start_addr;
            req_first = 1'b1;
            state_d   = ST_SKIP;
          end else begin
            start_rej = 1'b1;
          end
        end
      end
      ST_SKIP: begin
        if (skip_q != '0) begin
          req_next = 1'b1;
          skip_d   = skip_q - SKIP_ONE;
        end else begin
          wcnt_d  = WCNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      // Buffer read latency stage: data is captured on the edge ending the last wait cycle
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          data_d  = read_data;
          state_d = ST_PRESENT;
        end else begin
          wcnt_d = wcnt_q - WCNT_ONE;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (rem_q == REM_ONE) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            req_next = 1'b1;
            rem_d    = rem_q - REM_ONE;
            wcnt_d   = WCNT_LOAD;
            state_d  = ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge scan_clk) begin
    if (scan_reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Mealy pulses are masked so that a start held during reset cannot leak through.
  assign read_req_first = req_first & ~scan_reset;
  assign read_req_next  = req_next  & ~scan_reset;
  assign err            = start_rej & ~scan_reset;
  assign out_valid      = (state_q == ST_PRESENT);
  assign out_last       = (state_q == ST_PRESENT) && (rem_q == REM_ONE);
  assign out_data       = data_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;

endmodule
